// File: rtl/tlb_refill_ctrl.sv
// ----------------------------------------------------------------------------
// tlb_refill_ctrl
//
// Sequences address-translation requests through a fully-associative TLB.
// On a hit, the translated address is returned directly. On a miss, the
// controller reads one PTE from a single-level page table. It then writes
// that PTE into the TLB using a round-robin victim and retries the lookup.
// An invalid PTE produces a page fault instead of a refill.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid / req_ready       translation request handshake (front end)
//   req_vaddr, ptbr             virtual address and page-table base,
//                               both captured when a request is accepted
//   resp_valid                  one-cycle result pulse, no backpressure
//   resp_paddr, resp_fault      result; paddr is 0 when a fault is reported
//   tlb_virt_addr               lookup address to the TLB (latched vaddr)
//   tlb_hit, tlb_phys_addr      combinational lookup result from the TLB
//   tlb_write_*                 single-cycle TLB refill write
//   ptw_req_valid/ready/addr    PTE read request to memory
//   ptw_resp_valid, ptw_resp_pte  PTE read data: [0] = valid, top bits = PPN
//   miss_cnt                    saturating count of TLB misses
//
// Every output is driven from a register. No input reaches an output
// through combinational logic.
// ----------------------------------------------------------------------------
module tlb_refill_ctrl #(
    parameter int ENTRY_NUM         = 16,
    parameter int VPN_WIDTH         = 20,
    parameter int PPN_WIDTH         = 20,
    parameter int PAGE_OFFSET_WIDTH = 12,
    parameter int PTE_ADDR_WIDTH    = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,

    // Front-end request / response
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [VPN_WIDTH+PAGE_OFFSET_WIDTH-1:0] req_vaddr,
    input  logic [PTE_ADDR_WIDTH-1:0]            ptbr,
    output logic                                 resp_valid,
    output logic [PPN_WIDTH+PAGE_OFFSET_WIDTH-1:0] resp_paddr,
    output logic                                 resp_fault,

    // TLB lookup and refill
    output logic [VPN_WIDTH+PAGE_OFFSET_WIDTH-1:0] tlb_virt_addr,
    input  logic                                 tlb_hit,
    input  logic [PPN_WIDTH+PAGE_OFFSET_WIDTH-1:0] tlb_phys_addr,
    output logic                                 tlb_write_en,
    output logic [$clog2(ENTRY_NUM)-1:0]         tlb_write_index,
    output logic [VPN_WIDTH-1:0]                 tlb_write_vpn,
    output logic [PPN_WIDTH-1:0]                 tlb_write_ppn,

    // Page-table walk memory port
    output logic                                 ptw_req_valid,
    input  logic                                 ptw_req_ready,
    output logic [PTE_ADDR_WIDTH-1:0]            ptw_req_addr,
    input  logic                                 ptw_resp_valid,
    input  logic [PPN_WIDTH+PAGE_OFFSET_WIDTH-1:0] ptw_resp_pte,

    // Statistics
    output logic [15:0]                          miss_cnt
);

    localparam int VA_W  = VPN_WIDTH + PAGE_OFFSET_WIDTH;
    localparam int PA_W  = PPN_WIDTH + PAGE_OFFSET_WIDTH;
    localparam int IDX_W = $clog2(ENTRY_NUM);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRY_NUM - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WALK_REQ,
        WALK_WAIT,
        REFILL,
        RESP
    } state_t;

    state_t                  state;
    logic [VA_W-1:0]         vaddr_q;
    logic [PTE_ADDR_WIDTH-1:0] ptbr_q;
    logic [PPN_WIDTH-1:0]    ppn_q;
    logic [IDX_W-1:0]        victim_q;

    // Fields of the latched virtual address and of the incoming PTE.
    logic [VPN_WIDTH-1:0]      vpn;
    logic [PTE_ADDR_WIDTH-1:0] pte_offset;
    logic                      pte_valid;
    logic [PPN_WIDTH-1:0]      pte_ppn;

    assign vpn        = vaddr_q[VA_W-1 -: VPN_WIDTH];
    // Each PTE is 4 bytes. The cast zero-extends the VPN, or truncates it,
    // so that the sum wraps modulo the memory address width.
    assign pte_offset = PTE_ADDR_WIDTH'({vpn, 2'b00});
    assign pte_valid  = ptw_resp_pte[0];
    assign pte_ppn    = ptw_resp_pte[PA_W-1 -: PPN_WIDTH];

    // The PTE permission and flag bits between the valid bit and the PPN
    // are not used by this controller.
    logic unused_pte_flags;
    assign unused_pte_flags = ^ptw_resp_pte[PAGE_OFFSET_WIDTH-1:1];

    // The lookup address and the refill fields are direct views of registers.
    assign tlb_virt_addr   = vaddr_q;
    assign tlb_write_index = victim_q;
    assign tlb_write_vpn   = vpn;
    assign tlb_write_ppn   = ppn_q;

    // ------------------------------------------------------------------------
    // Controller FSM. The state and all registered outputs are updated here.
    // ------------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=). Every
    // register then samples values from before the edge, whatever the
    // statement order inside this block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            vaddr_q       <= '0;
            ptbr_q        <= '0;
            ppn_q         <= '0;
            victim_q      <= '0;
            miss_cnt      <= '0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_paddr    <= '0;
            resp_fault    <= 1'b0;
            tlb_write_en  <= 1'b0;
            ptw_req_valid <= 1'b0;
            ptw_req_addr  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        vaddr_q   <= req_vaddr;
                        ptbr_q    <= ptbr;
                        req_ready <= 1'b0;
                        state     <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    if (tlb_hit) begin
                        resp_paddr <= tlb_phys_addr;
                        resp_fault <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        if (miss_cnt != 16'hFFFF) begin
                            miss_cnt <= miss_cnt + 16'd1;
                        end
                        // The address is computed once here. It then stays
                        // stable for the whole request handshake.
                        ptw_req_addr  <= ptbr_q + pte_offset;
                        ptw_req_valid <= 1'b1;
                        state         <= WALK_REQ;
                    end
                end

                WALK_REQ: begin
                    if (ptw_req_ready) begin
                        ptw_req_valid <= 1'b0;
                        state         <= WALK_WAIT;
                    end
                end

                WALK_WAIT: begin
                    // A response is accepted only here. A stray response in
                    // any other state is dropped.
                    if (ptw_resp_valid) begin
                        if (pte_valid) begin
                            ppn_q        <= pte_ppn;
                            tlb_write_en <= 1'b1;
                            state        <= REFILL;
                        end else begin
                            resp_paddr <= '0;
                            resp_fault <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end

                REFILL: begin
                    // The write strobe lasts one cycle. The victim pointer
                    // moves only here, so hits and faults never advance it.
                    tlb_write_en <= 1'b0;
                    victim_q     <= (victim_q == LAST_IDX) ? '0 : victim_q + 1'b1;
                    state        <= LOOKUP;
                end

                RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end

                default: begin
                    state         <= IDLE;
                    req_ready     <= 1'b1;
                    resp_valid    <= 1'b0;
                    tlb_write_en  <= 1'b0;
                    ptw_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tlb_refill_ctrl
//
// Directed bench for tlb_refill_ctrl. A small behavioural TLB answers the
// controller's lookups and absorbs its refill writes. The bench drives the
// memory port directly, step by step. Inputs change and outputs are sampled
// on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_tlb_refill_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_vaddr;
    logic [31:0] ptbr;
    logic        resp_valid;
    logic [31:0] resp_paddr;
    logic        resp_fault;
    logic [31:0] tlb_virt_addr;
    logic        tlb_hit;
    logic [31:0] tlb_phys_addr;
    logic        tlb_write_en;
    logic [3:0]  tlb_write_index;
    logic [19:0] tlb_write_vpn;
    logic [19:0] tlb_write_ppn;
    logic        ptw_req_valid;
    logic        ptw_req_ready;
    logic [31:0] ptw_req_addr;
    logic        ptw_resp_valid;
    logic [31:0] ptw_resp_pte;
    logic [15:0] miss_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int wr_count = 0;

    tlb_refill_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_vaddr       (req_vaddr),
        .ptbr            (ptbr),
        .resp_valid      (resp_valid),
        .resp_paddr      (resp_paddr),
        .resp_fault      (resp_fault),
        .tlb_virt_addr   (tlb_virt_addr),
        .tlb_hit         (tlb_hit),
        .tlb_phys_addr   (tlb_phys_addr),
        .tlb_write_en    (tlb_write_en),
        .tlb_write_index (tlb_write_index),
        .tlb_write_vpn   (tlb_write_vpn),
        .tlb_write_ppn   (tlb_write_ppn),
        .ptw_req_valid   (ptw_req_valid),
        .ptw_req_ready   (ptw_req_ready),
        .ptw_req_addr    (ptw_req_addr),
        .ptw_resp_valid  (ptw_resp_valid),
        .ptw_resp_pte    (ptw_resp_pte),
        .miss_cnt        (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural fully-associative TLB: combinational lookup, clocked write.
    logic        m_v   [16];
    logic [19:0] m_vpn [16];
    logic [19:0] m_ppn [16];

    always_comb begin
        tlb_hit       = 1'b0;
        tlb_phys_addr = '0;
        for (int i = 0; i < 16; i++) begin
            if (m_v[i] && m_vpn[i] == tlb_virt_addr[31:12]) begin
                tlb_hit       = 1'b1;
                tlb_phys_addr = {m_ppn[i], tlb_virt_addr[11:0]};
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_v[i] <= 1'b0;
        end else if (tlb_write_en) begin
            m_v[tlb_write_index]   <= 1'b1;
            m_vpn[tlb_write_index] <= tlb_write_vpn;
            m_ppn[tlb_write_index] <= tlb_write_ppn;
        end
    end

    always @(posedge clk) begin
        if (rst_n && tlb_write_en) wr_count <= wr_count + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && req_ready !== 1'b1; k++) @(negedge clk);
        check("return_to_idle", req_ready, 1);
    endtask

    // One request that misses, with a zero-wait memory. Called on a falling
    // edge while the controller is idle.
    task automatic miss_txn(input logic [31:0] va, input logic [31:0] pt,
                            input logic [31:0] pte, input logic [31:0] exp_addr,
                            input logic [3:0] exp_idx, input logic [31:0] exp_pa,
                            input logic [15:0] exp_miss);
        check("accept_ready", req_ready, 1);
        req_valid = 1'b1; req_vaddr = va; ptbr = pt;
        @(negedge clk);                                   // cycle 1: LOOKUP
        req_valid = 1'b0; req_vaddr = 32'hFFFF_FFFF; ptbr = 32'hFFFF_FFFF;
        check("lookup_vaddr", tlb_virt_addr, va);
        check("lookup_ready", req_ready, 0);
        @(negedge clk);                                   // cycle 2: WALK_REQ
        check("walk_req_valid", ptw_req_valid, 1);
        check("walk_req_addr", ptw_req_addr, exp_addr);
        ptw_req_ready = 1'b1;
        @(negedge clk);                                   // cycle 3: WALK_WAIT
        ptw_req_ready = 1'b0;
        check("walk_req_dropped", ptw_req_valid, 0);
        ptw_resp_valid = 1'b1; ptw_resp_pte = pte;
        @(negedge clk);                                   // cycle 4
        ptw_resp_valid = 1'b0;
        if (pte[0]) begin
            check("refill_en", tlb_write_en, 1);
            check("refill_idx", tlb_write_index, exp_idx);
            check("refill_vpn", tlb_write_vpn, va[31:12]);
            check("refill_ppn", tlb_write_ppn, pte[31:12]);
            @(negedge clk);                               // cycle 5: retry
            check("refill_one_cycle", tlb_write_en, 0);
            check("retry_no_resp", resp_valid, 0);
            @(negedge clk);                               // cycle 6: RESP
            check("miss_resp_valid", resp_valid, 1);
            check("miss_resp_fault", resp_fault, 0);
        end else begin
            check("fault_resp_valid", resp_valid, 1);
            check("fault_resp_fault", resp_fault, 1);
            check("fault_no_write", tlb_write_en, 0);
        end
        check("resp_paddr", resp_paddr, exp_pa);
        check("miss_cnt", miss_cnt, exp_miss);
        @(negedge clk);
        check("resp_one_cycle", resp_valid, 0);
        wait_idle();
    endtask

    int wr0;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_vaddr = '0; ptbr = '0;
        ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0; ptw_resp_pte = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_paddr", resp_paddr, 0);
        check("rst_ptw_valid", ptw_req_valid, 0);
        check("rst_ptw_addr", ptw_req_addr, 0);
        check("rst_write_en", tlb_write_en, 0);
        check("rst_write_idx", tlb_write_index, 0);
        check("rst_virt_addr", tlb_virt_addr, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: cold miss, refill into entry 0, retry hits
        miss_txn(32'h0001_2345, 32'h8000_0000, 32'h000A_B001, 32'h8000_0048,
                 4'd0, 32'h000A_B345, 16'd1);

        // 2: hit on the same page, result two cycles after accept
        req_valid = 1'b1; req_vaddr = 32'h0001_2FFF; ptbr = 32'h8000_0000;
        @(negedge clk);
        req_valid = 1'b0;
        check("hit_not_early", resp_valid, 0);
        @(negedge clk);
        check("hit_resp_valid", resp_valid, 1);
        check("hit_resp_paddr", resp_paddr, 32'h000A_BFFF);
        check("hit_resp_fault", resp_fault, 0);
        check("hit_miss_cnt", miss_cnt, 1);
        @(negedge clk);
        wait_idle();

        // 3: invalid PTE -> fault, no refill, victim pointer unchanged
        wr0 = wr_count;
        miss_txn(32'h0003_4000, 32'h8000_0000, 32'h000C_D000, 32'h8000_00D0,
                 4'd1, 32'h0000_0000, 16'd2);
        check("fault_wr_count", wr_count, wr0);
        check("fault_victim_kept", tlb_write_index, 1);

        // 4: seventeen distinct pages after reset -> indices 0..15 then 0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            miss_txn({20'h00100 + 20'(i), 12'h0AB}, 32'h0000_1000,
                     {20'h00200 + 20'(i), 12'h001},
                     32'h0000_1000 + 32'((32'h100 + i) * 4),
                     4'(i % 16), {20'h00200 + 20'(i), 12'h0AB}, 16'(i + 1));
        end
        check("wrap_victim_next", tlb_write_index, 1);

        // 5: memory stalls for 5 cycles; address stays put, a stray response
        //    and a stray request are both ignored
        req_valid = 1'b1; req_vaddr = 32'h0005_5123; ptbr = 32'h0000_4000;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_vaddr = 32'hDEAD_BEEF;
        for (int j = 0; j < 5; j++) begin
            check("stall_valid", ptw_req_valid, 1);
            check("stall_addr", ptw_req_addr, 32'h0000_4154);
            check("stall_vaddr", tlb_virt_addr, 32'h0005_5123);
            ptw_resp_valid = (j == 2); ptw_resp_pte = 32'h0007_7001;
            @(negedge clk);
        end
        ptw_resp_valid = 1'b0; req_valid = 1'b0;
        check("stall_end_valid", ptw_req_valid, 1);
        check("stall_end_addr", ptw_req_addr, 32'h0000_4154);
        check("stall_no_write", tlb_write_en, 0);
        ptw_req_ready = 1'b1;
        @(negedge clk);
        ptw_req_ready = 1'b0;
        ptw_resp_valid = 1'b1; ptw_resp_pte = 32'h0009_9001;
        @(negedge clk);
        ptw_resp_valid = 1'b0;
        check("stall_refill_en", tlb_write_en, 1);
        check("stall_refill_idx", tlb_write_index, 1);
        check("stall_refill_ppn", tlb_write_ppn, 20'h00099);
        repeat (2) @(negedge clk);
        check("stall_resp_valid", resp_valid, 1);
        check("stall_resp_paddr", resp_paddr, 32'h0009_9123);
        check("stall_miss_cnt", miss_cnt, 18);
        @(negedge clk);
        wait_idle();

        // 6: reset during WALK_WAIT, then a late PTE arrives
        req_valid = 1'b1; req_vaddr = 32'h0006_6000; ptbr = 32'h0000_0000;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        ptw_req_ready = 1'b1;
        @(negedge clk);
        ptw_req_ready = 1'b0;
        check("pre_rst_in_wait", ptw_req_valid, 0);
        wr0 = wr_count;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", req_ready, 1);
        check("midrst_write_en", tlb_write_en, 0);
        check("midrst_miss_cnt", miss_cnt, 0);
        ptw_resp_valid = 1'b1; ptw_resp_pte = 32'h0001_1001;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        ptw_resp_valid = 1'b0;
        check("late_pte_no_write", wr_count, wr0);
        check("late_pte_ready", req_ready, 1);
        check("late_pte_resp", resp_valid, 0);
        check("late_pte_miss_cnt", miss_cnt, 0);
        check("late_pte_victim", tlb_write_index, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
